// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit.
// MIPS_BNE_EN adds the BNE state and opcode.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
`ifdef MIPS_BNE_EN
    JUMP    = 4'd11,
    BNE     = 4'd12
`else
    JUMP    = 4'd11
`endif
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_SLT = 3'b111;

endpackage

// File: rtl/mips_controller_if.sv
// Control bundle between the controller (master) and the datapath (slave).
interface mips_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic [3:0] state;

  modport master (
    input  op, funct, zero,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, state
  );

  modport slave (
    output op, funct, zero,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, state
  );
endinterface

// File: rtl/mips_alu_decoder.sv
// Combinational ALUOp + funct to ALUControl decode.
module mips_alu_decoder
  import mips_pkg::*;
(
  input  alu_op_e    alu_op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_ctrl_o
);

  always_comb begin
    alu_ctrl_o = ALUC_ADD;
    case (alu_op_i)
      ALUOP_SUB:   alu_ctrl_o = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FUNCT_SUB: alu_ctrl_o = ALUC_SUB;
          FUNCT_AND: alu_ctrl_o = ALUC_AND;
          FUNCT_OR:  alu_ctrl_o = ALUC_OR;
          FUNCT_SLT: alu_ctrl_o = ALUC_SLT;
          default:   alu_ctrl_o = ALUC_ADD;
        endcase
      end
      default:     alu_ctrl_o = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/mips_controller.sv
// Multicycle Moore control unit for the shared-memory MIPS core.
// MIPS_BNE_EN enables the bne opcode and its BNE state.
module mips_controller
  import mips_pkg::*;
(
  input logic             clk,
  input logic             RESET,
  mips_controller_if.master bus
);

  state_e state_q, state_d, s_eff;
  alu_op_e alu_op;
  logic iord, irwrite, memwrite, regdst, memtoreg, regwrite, srca;
  logic [1:0] srcb, pcsrc;
  logic pcwrite, branch, branch_ne;

  always_ff @(posedge clk) begin
    if (RESET) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
`ifdef MIPS_BNE_EN
          OP_BNE:       state_d = BNE;
`endif
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: begin
        if (bus.op == OP_LW)      state_d = MEMRD;
        else if (bus.op == OP_SW) state_d = MEMWR;
        else                      state_d = FETCH;
      end
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // Under reset the selects present FETCH values; the write enables are killed below.
  always_comb begin
    s_eff     = RESET ? FETCH : state_q;
    iord      = 1'b0;
    irwrite   = 1'b0;
    memwrite  = 1'b0;
    regdst    = 1'b0;
    memtoreg  = 1'b0;
    regwrite  = 1'b0;
    srca      = 1'b0;
    srcb      = 2'b00;
    alu_op    = ALUOP_ADD;
    pcsrc     = 2'b00;
    pcwrite   = 1'b0;
    branch    = 1'b0;
    branch_ne = 1'b0;
    case (s_eff)
      FETCH: begin
        irwrite = 1'b1;
        srcb    = 2'b01;
        pcwrite = 1'b1;
      end
      DECODE:  srcb = 2'b11;
      MEMADR: begin
        srca = 1'b1;
        srcb = 2'b10;
      end
      MEMRD:   iord = 1'b1;
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        srca   = 1'b1;
        alu_op = ALUOP_FUNCT;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BRANCH: begin
        srca   = 1'b1;
        alu_op = ALUOP_SUB;
        pcsrc  = 2'b01;
        branch = 1'b1;
      end
`ifdef MIPS_BNE_EN
      BNE: begin
        srca      = 1'b1;
        alu_op    = ALUOP_SUB;
        pcsrc     = 2'b01;
        branch_ne = 1'b1;
      end
`endif
      ADDIEX: begin
        srca = 1'b1;
        srcb = 2'b10;
      end
      ADDIWB:  regwrite = 1'b1;
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  mips_alu_decoder u_alu_dec (
    .alu_op_i   (alu_op),
    .funct_i    (bus.funct),
    .alu_ctrl_o (bus.ALUControl)
  );

  assign bus.IorD     = iord;
  assign bus.IRWrite  = irwrite  & ~RESET;
  assign bus.MemWrite = memwrite & ~RESET;
  assign bus.RegDst   = regdst;
  assign bus.MemtoReg = memtoreg;
  assign bus.RegWrite = regwrite & ~RESET;
  assign bus.ALUSrcA  = srca;
  assign bus.ALUSrcB  = srcb;
  assign bus.PCSrc    = pcsrc;
  assign bus.PCEn     = (pcwrite | (branch & bus.zero) | (branch_ne & ~bus.zero)) & ~RESET;
  assign bus.state    = state_q;

endmodule

// File: doc/mips_controller.md
# mips_controller

Multicycle control unit for the shared-memory MIPS core: a Moore state machine that sequences fetch, decode, execute, memory and write-back across several cycles. It drives every select and write-enable of the datapath, including the single unified memory port (address, write data, MemWrite). It sits beside the datapath inside `mips` and decodes the instruction register's `op`/`funct` fields plus the ALU `zero` flag.

## Interface
- No parameters; all encodings come from the shared package.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `op`  in  6  instruction bits [31:26] from the instruction register.
- `funct`  in  6  instruction bits [5:0].
- `zero`  in  1  ALU result is zero.
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `MemWrite`  out  1  unified memory write strobe.
- `IRWrite`  out  1  instruction register load.
- `RegDst`  out  1  write register select: 0 = rt, 1 = rd.
- `MemtoReg`  out  1  register write data select: 0 = ALUOut, 1 = Data register.
- `RegWrite`  out  1  register file write.
- `ALUSrcA`  out  1  ALU A select: 0 = PC, 1 = register A.
- `ALUSrcB`  out  2  ALU B select: 00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- `ALUControl`  out  3  ALU operation select.
- `PCSrc`  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `PCEn`  out  1  PC register load.
- `state`  out  4  current state, for debug and the bench.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSrc=00, PCWrite=1. Next state DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=ADD (branch target into ALUOut). Next state by `op`:
  - 100011 (lw) and 101011 (sw) -> MEMADR
  - 000000 -> RTYPEEX
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - any other opcode -> FETCH, executed as a nop with no writes.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1 -> MEMWB. MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
- MEMWR: IorD=1, MemWrite=1 -> FETCH.
- RTYPEEX: ALUSrcA=1, ALUSrcB=00, ALUOp=FUNCT -> ALUWB. ALUWB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCSrc=01, Branch=1 -> FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD -> ADDIWB. ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
- JUMP: PCSrc=10, PCWrite=1 -> FETCH.
- Any output not listed for a state is 0.
- PCEn = PCWrite | (Branch & zero).
- ALU decode, ALUOp -> ALUControl:
  - ADD -> 010; SUB -> 110
  - FUNCT: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, other funct -> 010.

## Timing
- State register updates on the rising edge of `clk`. All outputs are combinational from `state`, except PCEn, which also depends on `zero`.
- RESET high at an edge loads FETCH, including mid-instruction; any partially executed instruction is abandoned.
- While RESET is high, PCEn, IRWrite, RegWrite and MemWrite are forced to 0 and the select outputs carry their FETCH values. After RESET drops, the first FETCH cycle is live.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- MemWrite is high for exactly one cycle per sw, with IorD=1 in that same cycle.

## Configuration
- `MIPS_BNE_EN` defined: opcode 000101 (bne) in DECODE goes to state BNE. BNE has the same outputs as BRANCH but BranchNe=1, and PCEn = PCWrite | (Branch & zero) | (BranchNe & ~zero). Latency is 3 cycles.
- `MIPS_BNE_EN` undefined: opcode 000101 is an unknown opcode (DECODE -> FETCH), and there is no BNE state.

## Structure
- `mips_pkg` holds: the state enum (4-bit), opcode and funct localparams, the ALUOp enum (ADD, SUB, FUNCT), and the ALUControl codes.
- Sub-module `mips_alu_decoder` is combinational: ALUOp + funct -> ALUControl.
- `mips_controller` contains the state register, next-state logic, output decode and PCEn.

## Test plan
- Reset: hold RESET 2 cycles -> state=FETCH, PCEn=0, MemWrite=0. On the first cycle after release, PCEn=1, IRWrite=1, ALUSrcB=01.
- Fixed program sequence: lw, sw, lw, addi, sw, j, add, sw -> states follow the listed paths; 33 cycles total; MemWrite pulses exactly 3 times, each with IorD=1.
- beq with zero=1 in BRANCH -> PCEn=1, PCSrc=01, ALUControl=110. Same test with zero=0 -> PCEn=0. Both end in FETCH after 3 cycles.
- R-type funct sweep through RTYPEEX (100000/100010/100100/100101/101010/111111) -> ALUControl 010/110/000/001/111/010. ALUWB has RegDst=1 and RegWrite=1.
- Unknown opcode 111111 -> DECODE -> FETCH; RegWrite, MemWrite and PCEn stay 0 in DECODE.
- RESET asserted during MEMWR -> MemWrite forced to 0 in that cycle and next state is FETCH.
- With `MIPS_BNE_EN`: op=000101, zero=0 -> PCEn=1 in BNE. Without the macro: op=000101 -> DECODE -> FETCH.
